// File: rtl/linear_network_collect_seq_4_1.sv
// rtl/linear_network_collect_seq_4_1.sv - linear collection chain gathering node words onto one tagged output port
module linear_network_collect_seq_4_1 #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_NODE   = 4,
    localparam int COMMAND_WIDTH = $clog2(NUM_NODE)
) (
    input  logic                           CLK,
    input  logic                           rst,
    input  logic                           i_en,
    input  logic [NUM_NODE-1:0]            i_valid,
    input  logic [NUM_NODE*DATA_WIDTH-1:0] i_data_bus,
    output logic [NUM_NODE-1:0]            o_ready,
    output logic                           o_valid,
    output logic [DATA_WIDTH-1:0]          o_data_bus,
    output logic [COMMAND_WIDTH-1:0]       o_src,
    input  logic                           i_out_ready
);

    // Stage k holds one word; stage 0 feeds the output port.
    logic [NUM_NODE-1:0]      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    data_q [NUM_NODE];
    logic [DATA_WIDTH-1:0]    data_d [NUM_NODE];
    logic [COMMAND_WIDTH-1:0] src_q  [NUM_NODE];
    logic [COMMAND_WIDTH-1:0] src_d  [NUM_NODE];
    // Priority per stage: 0 = upstream first, 1 = local first.
    logic [NUM_NODE-1:0]      pri_q, pri_d;

    logic                     en;
    logic [NUM_NODE-1:0]      taken;
    logic [NUM_NODE-1:0]      free;
    logic [NUM_NODE-1:0]      up_cand;
    logic [NUM_NODE-1:0]      loc_cand;
    logic [NUM_NODE-1:0]      grant_up;
    logic [NUM_NODE-1:0]      grant_loc;

    // Reset also blocks handshakes so no word is accepted or consumed while it is asserted.
    assign en = i_en && !rst;

    // Head of the chain, zeroed whenever it is not presenting a word.
    always_comb begin
        o_valid    = valid_q[0] && en;
        o_data_bus = '0;
        o_src      = '0;
        if (o_valid) begin
            o_data_bus = data_q[0];
            o_src      = src_q[0];
        end
    end

    // Arbitration and next-state; the vacancy ripples from the output stage towards the tail.
    always_comb begin
        int up_idx;
        up_idx    = 0;
        valid_d   = valid_q;
        data_d    = data_q;
        src_d     = src_q;
        pri_d     = pri_q;
        taken     = '0;
        free      = '0;
        up_cand   = '0;
        loc_cand  = '0;
        grant_up  = '0;
        grant_loc = '0;
        for (int k = 0; k < NUM_NODE; k++) begin
            up_idx = (k < NUM_NODE - 1) ? k + 1 : k;
            if (k == 0) begin
                taken[k] = i_out_ready && en;
            end else begin
                taken[k] = grant_up[k-1];
            end
            free[k]     = !valid_q[k] || taken[k];
            up_cand[k]  = free[k] && en && (k < NUM_NODE - 1) && valid_q[up_idx];
            loc_cand[k] = free[k] && en && i_valid[k];
            grant_up[k]  = up_cand[k] && (!loc_cand[k] || !pri_q[k]);
            grant_loc[k] = loc_cand[k] && (!up_cand[k] || pri_q[k]);
            if (up_cand[k] && loc_cand[k]) begin
                pri_d[k] = !pri_q[k];
            end
            if (grant_up[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = data_q[up_idx];
                src_d[k]   = src_q[up_idx];
            end else if (grant_loc[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
                src_d[k]   = COMMAND_WIDTH'(k);
            end else if (taken[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        o_ready = grant_loc;
    end

    // Stage registers and priority bits; reset discards everything in flight.
    always_ff @(posedge CLK) begin
        if (rst) begin
            valid_q <= '0;
            pri_q   <= '0;
            for (int k = 0; k < NUM_NODE; k++) begin
                data_q[k] <= '0;
                src_q[k]  <= '0;
            end
        end else if (i_en) begin
            valid_q <= valid_d;
            pri_q   <= pri_d;
            for (int k = 0; k < NUM_NODE; k++) begin
                data_q[k] <= data_d[k];
                src_q[k]  <= src_d[k];
            end
        end
    end

endmodule

// File: tb/tb_linear_network_collect_seq_4_1.sv
// tb/tb_linear_network_collect_seq_4_1.sv - self-checking bench for the linear collection chain
module tb_linear_network_collect_seq_4_1;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int CW = 2;
    localparam int SB = 128;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic          i_en = 1'b1;
    logic [N-1:0]  i_valid = '0;
    logic [N*DW-1:0] i_data_bus = '0;
    logic [N-1:0]  o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data_bus;
    logic [CW-1:0] o_src;
    logic          i_out_ready = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Node sources and per-node expected-order scoreboard.
    logic [7:0] sbuf [N][SB];
    int shead [N];
    int stail [N];
    logic [7:0] ebuf [N][SB];
    int ehead [N];
    int etail [N];
    bit [N-1:0] xfer = '0;

    // Output log.
    int out_cyc[$];
    int out_src[$];
    int out_dat[$];

    // Behavioural model: slot array, index N is a permanently empty slot.
    bit       mv [N+1];
    logic [7:0] md [N+1];
    int       ms [N+1];
    bit       mp [N];

    linear_network_collect_seq_4_1 #(.DATA_WIDTH(DW), .NUM_NODE(N)) dut (
        .CLK(CLK), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_data_bus(i_data_bus),
        .o_ready(o_ready), .o_valid(o_valid), .o_data_bus(o_data_bus), .o_src(o_src),
        .i_out_ready(i_out_ready)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            shead[k] = 0; stail[k] = 0; ehead[k] = 0; etail[k] = 0;
            mp[k] = 0;
        end
        for (int k = 0; k <= N; k++) begin
            mv[k] = 0; md[k] = 0; ms[k] = 0;
        end
    end

    // Compare process: model outputs vs DUT every cycle, then advance the model.
    always @(negedge CLK) begin
        bit en_m, prev, opn, hu, hl, gu, gl;
        bit m_ov;
        logic [7:0] m_od;
        int m_os;
        logic [N-1:0] m_rdy;
        bit nv [N];
        logic [7:0] nd [N];
        int ns [N];
        bit np [N];
        int s;
        en_m = i_en && !rst;
        m_ov = mv[0] && en_m;
        m_od = m_ov ? md[0] : 8'h00;
        m_os = m_ov ? ms[0] : 0;
        m_rdy = '0;
        prev = en_m && i_out_ready;
        for (int k = 0; k < N; k++) begin
            nv[k] = mv[k]; nd[k] = md[k]; ns[k] = ms[k]; np[k] = mp[k];
            opn = !mv[k] || prev;
            hu = opn && en_m && mv[k+1];
            hl = opn && en_m && i_valid[k];
            gu = hu && !(hl && mp[k]);
            gl = hl && !(hu && !mp[k]);
            m_rdy[k] = gl;
            if (gu) begin
                nv[k] = 1; nd[k] = md[k+1]; ns[k] = ms[k+1];
            end else if (gl) begin
                nv[k] = 1; nd[k] = i_data_bus[k*DW +: DW]; ns[k] = k;
            end else if (prev) begin
                nv[k] = 0;
            end
            if (hu && hl) np[k] = !mp[k];
            prev = gu;
        end
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                nv[k] = 0; nd[k] = 0; ns[k] = 0; np[k] = 0;
            end
        end
        chk("o_valid", o_valid, m_ov);
        chk("o_data_bus", o_data_bus, m_od);
        chk("o_src", o_src, m_os);
        chk("o_ready", o_ready, m_rdy);

        // Scoreboard: acceptance order per node must equal emission order per source.
        xfer = i_valid & o_ready;
        for (int k = 0; k < N; k++) begin
            if (xfer[k]) begin
                ebuf[k][etail[k] % SB] = i_data_bus[k*DW +: DW];
                etail[k]++;
            end
        end
        if (o_valid && i_out_ready) begin
            s = int'(o_src);
            out_cyc.push_back(cyc);
            out_src.push_back(s);
            out_dat.push_back(int'(o_data_bus));
            if (ehead[s] < etail[s]) begin
                chk("sb_order", o_data_bus, ebuf[s][ehead[s] % SB]);
                ehead[s]++;
            end else begin
                chk("sb_extra", etail[s] - ehead[s], 1);
            end
        end
        if (rst) begin
            for (int k = 0; k < N; k++) ehead[k] = etail[k];
        end
        for (int k = 0; k < N; k++) begin
            mv[k] = nv[k]; md[k] = nd[k]; ms[k] = ns[k]; mp[k] = np[k];
        end
    end

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (shead[k] < stail[k]) begin
                i_valid[k] = 1'b1;
                i_data_bus[k*DW +: DW] = sbuf[k][shead[k] % SB];
            end else begin
                i_valid[k] = 1'b0;
                i_data_bus[k*DW +: DW] = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int k = 0; k < N; k++) if (xfer[k]) shead[k]++;
        drive();
    endtask

    task automatic push(input int k, input logic [7:0] d);
        sbuf[k][stail[k] % SB] = d;
        stail[k]++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int m, c0, b;
        // Reset state.
        tick();
        #3;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_ready", o_ready, 0);
        chk("rst_o_data", o_data_bus, 0);
        chk("rst_o_src", o_src, 0);
        tick();
        rst = 1'b0;

        // Single word from the farthest node: latency N.
        m = out_cyc.size();
        push(3, 8'hA5);
        c0 = cyc;
        #3;
        chk("t1_accept", o_ready, 4'b1000);
        repeat (8) tick();
        chk("t1_count", out_cyc.size() - m, 1);
        if (out_cyc.size() > m) begin
            chk("t1_latency", out_cyc[m] - c0, 4);
            chk("t1_src", out_src[m], 3);
            chk("t1_data", out_dat[m], 32'hA5);
        end

        // Saturation: all nodes always valid, sink always ready.
        m = out_cyc.size();
        for (int s = 0; s < 10; s++)
            for (int k = 0; k < N; k++) push(k, 8'((k << 4) | s));
        repeat (50) tick();
        chk("t2_count", out_cyc.size() - m, 40);
        if (out_cyc.size() >= m + 16) begin
            for (int i = 0; i < 16; i++) begin
                chk("t2_contig", out_cyc[m+i] - out_cyc[m], i);
                chk("t2_node0_alt", out_src[m+i] == 0, (i % 2) == 0);
            end
        end

        // Sink stall with all nodes valid.
        m = out_cyc.size();
        for (int s = 0; s < 6; s++)
            for (int k = 0; k < N; k++) push(k, 8'(8'h80 | (k << 4) | s));
        tick();
        tick();
        i_out_ready = 1'b0;
        repeat (5) tick();
        #3;
        chk("t3_stall_ready", o_ready, 0);
        chk("t3_stall_valid", o_valid, 1);
        tick();
        i_out_ready = 1'b1;
        repeat (40) tick();
        chk("t3_count", out_cyc.size() - m, 24);

        // Nodes 1 and 2 together on an empty chain with fresh priorities.
        do_reset();
        m = out_cyc.size();
        push(1, 8'h11);
        push(1, 8'h12);
        push(2, 8'h21);
        b = cyc;
        tick();
        #3;
        chk("t4_up_first", o_ready[1], 0);
        repeat (8) tick();
        chk("t4_count", out_cyc.size() - m, 3);
        if (out_cyc.size() >= m + 3) begin
            chk("t4_c0", out_cyc[m] - b, 2);
            chk("t4_s0", out_src[m], 1);
            chk("t4_d0", out_dat[m], 32'h11);
            chk("t4_c1", out_cyc[m+1] - b, 3);
            chk("t4_s1", out_src[m+1], 2);
            chk("t4_c2", out_cyc[m+2] - b, 4);
            chk("t4_d2", out_dat[m+2], 32'h12);
        end

        // Enable low mid-stream.
        m = out_cyc.size();
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < N; k++) push(k, 8'(8'h40 | (k << 4) | s));
        repeat (3) tick();
        i_en = 1'b0;
        repeat (3) begin
            #3;
            chk("t5_en_valid", o_valid, 0);
            chk("t5_en_ready", o_ready, 0);
            tick();
        end
        i_en = 1'b1;
        repeat (40) tick();
        chk("t5_count", out_cyc.size() - m, 16);

        // Reset with three words in flight.
        push(1, 8'hC1);
        push(2, 8'hC2);
        push(3, 8'hC3);
        tick();
        rst = 1'b1;
        #3;
        chk("t6_rst_valid", o_valid, 0);
        tick();
        rst = 1'b0;
        #3;
        chk("t6_post_valid", o_valid, 0);
        chk("t6_post_data", o_data_bus, 0);
        chk("t6_post_src", o_src, 0);
        m = out_cyc.size();
        repeat (10) tick();
        chk("t6_no_emit", out_cyc.size() - m, 0);

        for (int k = 0; k < N; k++) begin
            chk("sb_drain", etail[k] - ehead[k], 0);
            chk("src_drain", stail[k] - shead[k], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
